// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// buffers returned words in a 2-entry FIFO presented to decode with valid/ready.
module fetch_unit #(
  parameter int unsigned  N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic [31:0]  instr,
  output logic [N-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready
);

  logic [N-1:0] r_pc;
  logic [1:0]   r_count;
  logic         r_inflight;
  logic [N-1:0] r_flight_pc;
  logic [31:0]  r_head_instr;
  logic [N-1:0] r_head_pc;
  logic [31:0]  r_tail_instr;
  logic [N-1:0] r_tail_pc;

  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  logic [2:0]   w_occupancy;

  assign instr_valid = reset & (r_count != 2'd0) & ~redirect;
  assign w_pop       = instr_valid & instr_ready;
  assign w_push      = r_inflight;

  // Issue only if the word now in flight plus the queue still leave a free slot,
  // so a response always has somewhere to land.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_issue     = reset & ~redirect & (w_occupancy < (3'd2 + {2'b00, w_pop}));

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;

  // Head-of-queue is a register, so only reset can reach instr/instr_pc combinationally.
  assign instr    = reset ? r_head_instr : 32'd0;
  assign instr_pc = reset ? r_head_pc    : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_count      <= 2'd0;
      r_inflight   <= 1'b0;
      r_flight_pc  <= '0;
      // NOTE: queue entries are explicitly cleared because instr/instr_pc must read 0
      // after reset until the first word arrives.
      r_head_instr <= 32'd0;
      r_head_pc    <= '0;
      r_tail_instr <= 32'd0;
      r_tail_pc    <= '0;
    end else if (redirect) begin
      r_pc       <= {redirect_pc[N-1:2], 2'b00};
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      if (w_issue) begin
        r_pc        <= r_pc + N'(4);
        r_flight_pc <= r_pc;
      end
      r_inflight <= w_issue;

      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_instr <= imem_rdata;
            r_head_pc    <= r_flight_pc;
          end else begin
            r_tail_instr <= imem_rdata;
            r_tail_pc    <= r_flight_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          // With one entry left the head keeps its stale value instead of loading the tail.
          if (r_count == 2'd2) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head_instr <= imem_rdata;
            r_head_pc    <= r_flight_pc;
          end else begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_tail_instr <= imem_rdata;
            r_tail_pc    <= r_flight_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables for the fixed scenarios, then random ready/redirect/reset
// traffic compared against a queue-based model of the fetch rules.
module tb_fetch_unit;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;

  logic        wr_req;
  logic [63:0] wr_addr;
  logic [31:0] wr_rdata;
  logic [31:0] wr_instr;
  logic [63:0] wr_instr_pc;
  logic        wr_valid;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fetch_unit #(.N(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  fetch_unit #(.N(64), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_rdata(wr_rdata), .redirect(1'b0), .redirect_pc(64'd0),
    .instr(wr_instr), .instr_pc(wr_instr_pc), .instr_valid(wr_valid), .instr_ready(1'b1)
  );

  // Instruction memory: returns a word derived from the previous cycle's address.
  always @(posedge clk) begin
    imem_rdata <= {16'hF840, imem_addr[15:0]};
    wr_rdata   <= {16'hF840, wr_addr[15:0]};
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rdr;
    logic [63:0] rpc;
    logic        chk;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        chk_w;
    logic        w_valid;
    logic [63:0] w_pc;
    logic [31:0] w_instr;
  } vec_t;

  function automatic logic [31:0] ins(input logic [63:0] pc);
    return {16'hF840, pc[15:0]};
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rdr,
                              input logic [63:0] rpc, input logic e_req,
                              input logic [63:0] e_addr, input logic e_valid,
                              input logic [63:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.chk = 1'b1;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    v.chk_w = 1'b0; v.w_valid = 1'b0; v.w_pc = 64'd0; v.w_instr = 32'd0;
    return v;
  endfunction

  function automatic vec_t mkw(input vec_t b, input logic w_valid, input logic [63:0] w_pc,
                               input logic [31:0] w_instr);
    vec_t v = b;
    v.chk_w = 1'b1; v.w_valid = w_valid; v.w_pc = w_pc; v.w_instr = w_instr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: fetched-but-undelivered PCs held in a plain queue.
  logic [63:0] m_q[$];
  bit          m_inf;
  logic [63:0] m_fpc;
  logic [63:0] m_pc;

  task automatic model_cycle(input vec_t v);
    bit e_valid, e_pop, e_req;
    int occ;
    if (!v.rst) begin
      check("mdl_rst_req", imem_req, 1'b0);
      check("mdl_rst_valid", instr_valid, 1'b0);
      check("mdl_rst_instr", instr, 32'd0);
      check("mdl_rst_pc", instr_pc, 64'd0);
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = 64'd0;
      return;
    end
    e_valid = (m_q.size() != 0) && !v.rdr;
    e_pop   = e_valid && v.rdy;
    occ     = m_q.size() + (m_inf ? 1 : 0) - (e_pop ? 1 : 0);
    e_req   = !v.rdr && (occ < 2);
    check("mdl_req", imem_req, e_req);
    if (e_req) check("mdl_addr", imem_addr, m_pc);
    check("mdl_valid", instr_valid, e_valid);
    if (e_valid) begin
      check("mdl_pc", instr_pc, m_q[0]);
      check("mdl_instr", instr, ins(m_q[0]));
    end
    if (v.rdr) begin
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = {v.rpc[63:2], 2'b00};
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_fpc);
      if (e_req) begin
        m_fpc = m_pc;
        m_pc  = m_pc + 64'd4;
      end
      m_inf = e_req;
    end
  endtask

  task automatic step(input vec_t v);
    reset       = v.rst;
    instr_ready = v.rdy;
    redirect    = v.rdr;
    redirect_pc = v.rpc;
    @(negedge clk);
    if (v.chk) begin
      check("tab_req", imem_req, v.e_req);
      if (v.e_req) check("tab_addr", imem_addr, v.e_addr);
      check("tab_valid", instr_valid, v.e_valid);
      check("tab_pc", instr_pc, v.e_pc);
      check("tab_instr", instr, v.e_instr);
    end
    if (v.chk_w) begin
      check("wrap_valid", wr_valid, v.w_valid);
      check("wrap_pc", wr_instr_pc, v.w_pc);
      check("wrap_instr", wr_instr, v.w_instr);
    end
    model_cycle(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tab[$];
    vec_t r;

    reset = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
    @(posedge clk);
    #1;

    // Reset release, stall from cycle 2 for 5 cycles, then drain; wrap instance alongside.
    tab.push_back(mkw(mk(0, 1, 0, 0, 0, 0,     0, 0,     0),       0, 0, 0));
    tab.push_back(mkw(mk(1, 1, 0, 0, 1, 0,     0, 0,     0),       0, 0, 0));
    tab.push_back(mkw(mk(1, 1, 0, 0, 1, 4,     0, 0,     0),       0, 0, 0));
    tab.push_back(mkw(mk(1, 0, 0, 0, 0, 0,     1, 0,     ins(0)),  1, WRAP_PC, ins(WRAP_PC)));
    tab.push_back(mkw(mk(1, 0, 0, 0, 0, 0,     1, 0,     ins(0)),  1, 64'd0, ins(64'd0)));
    tab.push_back(mkw(mk(1, 0, 0, 0, 0, 0,     1, 0,     ins(0)),  1, 64'd4, ins(64'd4)));
    tab.push_back(mkw(mk(1, 0, 0, 0, 0, 0,     1, 0,     ins(0)),  1, 64'd8, ins(64'd8)));
    tab.push_back(mk(1, 0, 0, 0, 0, 0,     1, 0,     ins(0)));
    tab.push_back(mk(1, 1, 0, 0, 1, 8,     1, 0,     ins(0)));
    tab.push_back(mk(1, 1, 0, 0, 1, 'hC,   1, 4,     ins(4)));
    tab.push_back(mk(1, 1, 0, 0, 1, 'h10,  1, 8,     ins(8)));
    tab.push_back(mk(1, 1, 0, 0, 1, 'h14,  1, 'hC,   ins('hC)));
    foreach (tab[i]) step(tab[i]);
    tab.delete();

    // In-flight kill, misaligned redirect, then reset with a full queue.
    tab.push_back(mk(0, 1, 0, 0,      0, 0,      0, 0,      0));
    tab.push_back(mk(1, 1, 0, 0,      1, 0,      0, 0,      0));
    tab.push_back(mk(1, 1, 0, 0,      1, 4,      0, 0,      0));
    tab.push_back(mk(1, 1, 0, 0,      1, 8,      1, 0,      ins(0)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'hC,    1, 4,      ins(4)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h10,   1, 8,      ins(8)));
    tab.push_back(mk(1, 1, 1, 'h100,  0, 0,      0, 'hC,    ins('hC)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h100,  0, 'hC,    ins('hC)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h104,  0, 'hC,    ins('hC)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h108,  1, 'h100,  ins('h100)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h10C,  1, 'h104,  ins('h104)));
    tab.push_back(mk(1, 1, 1, 'h207,  0, 0,      0, 'h108,  ins('h108)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h204,  0, 'h108,  ins('h108)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h208,  0, 'h108,  ins('h108)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h20C,  1, 'h204,  ins('h204)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'h210,  1, 'h208,  ins('h208)));
    tab.push_back(mk(1, 0, 0, 0,      0, 0,      1, 'h20C,  ins('h20C)));
    tab.push_back(mk(1, 0, 0, 0,      0, 0,      1, 'h20C,  ins('h20C)));
    tab.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0,      0));
    tab.push_back(mk(1, 1, 0, 0,      1, 0,      0, 0,      0));
    tab.push_back(mk(1, 1, 0, 0,      1, 4,      0, 0,      0));
    tab.push_back(mk(1, 1, 0, 0,      1, 8,      1, 0,      ins(0)));
    tab.push_back(mk(1, 1, 0, 0,      1, 'hC,    1, 4,      ins(4)));
    foreach (tab[i]) step(tab[i]);
    tab.delete();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      r = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
      r.chk = 1'b0;
      r.rst = ($urandom_range(0, 59) != 0);
      r.rdy = ($urandom_range(0, 9) < 7);
      r.rdr = ($urandom_range(0, 19) == 0);
      r.rpc = {$urandom, $urandom};
      step(r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
